// File: rtl/text_console_writer.sv
// text_console_writer: turns a byte stream into character-cell writes with cursor, control codes and wrap-and-clear.
module text_console_writer #(
  parameter int          COLS         = 240,
  parameter int          ROWS         = 135,
  parameter logic [7:0]  BLANK        = 8'h20,
  parameter logic [7:0]  DEFAULT_ATTR = 8'hF0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_attr,
  output logic        o_ready,
  output logic        o_wr_en,
  output logic [8:0]  o_wr_x,
  output logic [8:0]  o_wr_y,
  output logic [15:0] o_wr_data,
  output logic [8:0]  o_cur_x,
  output logic [8:0]  o_cur_y
);
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CLR_LINE   = 2'd1;
  localparam logic [1:0] CLR_SCREEN = 2'd2;
  localparam logic [8:0] X_LAST = 9'(COLS - 1);
  localparam logic [8:0] Y_LAST = 9'(ROWS - 1);
  logic [1:0]  state_q, state_d;
  logic [8:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [8:0]  clr_x_q, clr_x_d, clr_y_q, clr_y_d;
  logic [7:0]  attr_q, attr_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [8:0]  y_next;
  logic        clr_x_last, clr_y_last;
  assign o_ready    = (state_q == IDLE);
  assign y_next     = (cur_y_q == Y_LAST) ? 9'd0 : cur_y_q + 9'd1;
  assign clr_x_last = (clr_x_q == X_LAST);
  assign clr_y_last = (clr_y_q == Y_LAST);
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;
    attr_d    = attr_q;
    wr_en_d   = 1'b0;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_data_d = wr_data_q;
    if (state_q == IDLE && i_valid) begin
      attr_d = i_attr;
      case (i_data)
        8'h0D: cur_x_d = 9'd0;
        8'h0A: begin
          cur_x_d = 9'd0;
          cur_y_d = y_next;
          clr_x_d = 9'd0;
          state_d = CLR_LINE;
        end
        8'h08: if (cur_x_q != 9'd0) begin
          cur_x_d   = cur_x_q - 9'd1;
          wr_en_d   = 1'b1;
          wr_x_d    = cur_x_q - 9'd1;
          wr_y_d    = cur_y_q;
          wr_data_d = {BLANK, i_attr};
        end
        8'h0C: begin
          cur_x_d = 9'd0;
          cur_y_d = 9'd0;
          clr_x_d = 9'd0;
          clr_y_d = 9'd0;
          state_d = CLR_SCREEN;
        end
        default: begin
          wr_en_d   = 1'b1;
          wr_x_d    = cur_x_q;
          wr_y_d    = cur_y_q;
          wr_data_d = {i_data, i_attr};
          cur_x_d   = (cur_x_q == X_LAST) ? 9'd0 : cur_x_q + 9'd1;
          cur_y_d   = (cur_x_q == X_LAST) ? y_next : cur_y_q;
          clr_x_d   = 9'd0;
          state_d   = (cur_x_q == X_LAST) ? CLR_LINE : IDLE;
        end
      endcase
    end else if (state_q == CLR_LINE) begin
      wr_en_d   = 1'b1;
      wr_x_d    = clr_x_q;
      wr_y_d    = cur_y_q;
      wr_data_d = {BLANK, attr_q};
      clr_x_d   = clr_x_last ? 9'd0 : clr_x_q + 9'd1;
      state_d   = clr_x_last ? IDLE : CLR_LINE;
    end else if (state_q == CLR_SCREEN) begin
      wr_en_d   = 1'b1;
      wr_x_d    = clr_x_q;
      wr_y_d    = clr_y_q;
      wr_data_d = {BLANK, attr_q};
      clr_x_d   = clr_x_last ? 9'd0 : clr_x_q + 9'd1;
      clr_y_d   = !clr_x_last ? clr_y_q : clr_y_last ? 9'd0 : clr_y_q + 9'd1;
      state_d   = (clr_x_last && clr_y_last) ? IDLE : CLR_SCREEN;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLR_SCREEN;
      cur_x_q   <= 9'd0;
      cur_y_q   <= 9'd0;
      clr_x_q   <= 9'd0;
      clr_y_q   <= 9'd0;
      attr_q    <= DEFAULT_ATTR;
      wr_en_q   <= 1'b0;
      wr_x_q    <= 9'd0;
      wr_y_q    <= 9'd0;
      wr_data_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      clr_x_q   <= clr_x_d;
      clr_y_q   <= clr_y_d;
      attr_q    <= attr_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign o_wr_en   = wr_en_q;
  assign o_wr_x    = wr_x_q;
  assign o_wr_y    = wr_y_q;
  assign o_wr_data = wr_data_q;
  assign o_cur_x   = cur_x_q;
  assign o_cur_y   = cur_y_q;
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: scoreboard bench with a screen-level reference model for text_console_writer.
module tb_text_console_writer;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic [7:0]  i_attr = 8'h00;
  logic        o_ready, o_wr_en;
  logic [8:0]  o_wr_x, o_wr_y, o_cur_x, o_cur_y;
  logic [15:0] o_wr_data;
  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_attr(i_attr),
    .o_ready(o_ready), .o_wr_en(o_wr_en), .o_wr_x(o_wr_x), .o_wr_y(o_wr_y),
    .o_wr_data(o_wr_data), .o_cur_x(o_cur_x), .o_cur_y(o_cur_y)
  );
  always #5 i_clk = ~i_clk;
  typedef struct { int x; int y; int data; int rdy; } exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int mx = 0;
  int my = 0;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_line(input int y, input int a);
    for (int x = 0; x < COLS; x++) exp_q.push_back('{x, y, 'h2000 | a, (x == COLS - 1) ? 1 : 0});
  endtask
  task automatic push_screen(input int a);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        exp_q.push_back('{x, y, 'h2000 | a, (x == COLS - 1 && y == ROWS - 1) ? 1 : 0});
  endtask
  // Screen-level model: returns 1 when the byte starts a clear.
  task automatic model_byte(input int d, input int a, output bit ent);
    ent = 0;
    if (d == 'h0D) mx = 0;
    else if (d == 'h0A) begin
      mx = 0; my = (my + 1) % ROWS; push_line(my, a); ent = 1;
    end else if (d == 'h08) begin
      if (mx > 0) begin mx--; exp_q.push_back('{mx, my, 'h2000 | a, 1}); end
    end else if (d == 'h0C) begin
      mx = 0; my = 0; push_screen(a); ent = 1;
    end else begin
      exp_q.push_back('{mx, my, (d << 8) | a, (mx == COLS - 1) ? 0 : 1});
      if (mx == COLS - 1) begin
        mx = 0; my = (my + 1) % ROWS; push_line(my, a); ent = 1;
      end else mx++;
    end
  endtask
  always @(negedge i_clk) begin
    if (o_wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_x", int'(o_wr_x), e.x);
        chk("wr_y", int'(o_wr_y), e.y);
        chk("wr_data", int'(o_wr_data), e.data);
        chk("ready_at_write", int'(o_ready), e.rdy);
      end
    end
  end
  task automatic check_cur(input int ex, input int ey);
    chk("cur_x", int'(o_cur_x), ex);
    chk("cur_y", int'(o_cur_y), ey);
  endtask
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    bit ent;
    int n;
    n = 0;
    i_valid = 1'b1; i_data = d; i_attr = a;
    while (!o_ready && n < 200) begin @(posedge i_clk); #1; n++; end
    if (n == 200) chk("ready_timeout", 0, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_data = $urandom_range(0, 255);
    model_byte(int'(d), int'(a), ent);
    check_cur(mx, my);
    chk("ready_after_accept", int'(o_ready), ent ? 0 : 1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !o_ready) && n < 500) begin @(posedge i_clk); #1; n++; end
    if (n == 500) chk("drain_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask
  task automatic check_reset_outputs();
    chk("rst_wr_en", int'(o_wr_en), 0);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_wr_xyd", int'({o_wr_x, o_wr_y, o_wr_data}), 0);
    check_cur(0, 0);
  endtask
  initial begin
    int cnt;
    int r;
    logic [7:0] d;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs();
    push_screen('hF0);
    i_rst = 1'b0;
    drain();
    check_cur(0, 0);
    send("A", 8'h1C); check_cur(1, 0);
    drain();
    send(8'h0D, 8'h00);
    send("A", 8'h33); send("B", 8'h33); send("C", 8'h33); send("D", 8'h33);
    check_cur(0, 1);
    drain();
    send(8'h0A, 8'h21); send("x", 8'h21); send("y", 8'h21);
    check_cur(2, 2);
    send(8'h0A, 8'h65); check_cur(0, 0);
    drain();
    send("p", 8'h11); send("q", 8'h11); check_cur(2, 0);
    send(8'h0D, 8'h11); check_cur(0, 0);
    drain();
    send(8'h0A, 8'h77); drain();
    send(8'h08, 8'h77); check_cur(0, 1);
    send("a", 8'h5A); send("b", 8'h5A); send("c", 8'h5A); check_cur(3, 1);
    send(8'h08, 8'h5A); check_cur(2, 1);
    drain();
    send("z", 8'h42);
    send(8'h0C, 8'h42); check_cur(0, 0);
    drain();
    send(8'h0C, 8'h42);
    cnt = 0;
    r = 0;
    while (cnt < 5 && r < 100) begin
      @(posedge i_clk); #1; r++;
      if (o_wr_en) cnt++;
    end
    if (r == 100) chk("ff_write_timeout", 0, 1);
    i_rst = 1'b1;
    @(negedge i_clk); #1;
    exp_q.delete();
    mx = 0; my = 0;
    @(posedge i_clk); #1;
    check_reset_outputs();
    push_screen('hF0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    drain();
    check_cur(0, 0);
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 15);
      d = (r == 0) ? 8'h0A : (r == 1) ? 8'h0D : (r <= 3) ? 8'h08 :
          (r == 4 && $urandom_range(0, 7) == 0) ? 8'h0C : 8'($urandom_range(0, 255));
      send(d, 8'($urandom_range(0, 255)));
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
